// File: rtl/router_out_arb_pkg.sv
// Shared router packet types and the output-arbiter state encoding.
package RouterPkg;

  localparam int PKT_BYTES = 4;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/router_out_arb_rr_picker.sv
// Round-robin picker: one-hot winner is the first set req at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner
);

  int               idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// Round-robin output arbiter that serializes one 32-bit packet into four bytes.
// Optional per-port grant counters are built when ROUTER_ARB_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting; may grant when free_outbound=1 and a request is pending
// B0      | sending {src,dest}
// B1      | sending data[23:16]
// B2      | sending data[15:8]
// B3      | sending data[7:0], returns to IDLE
module router_out_arb
  import RouterPkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  pkt_t [NUM_REQ-1:0]       pkt_in,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     free_outbound,
  output logic                     put_outbound,
  output logic [7:0]               payload_outbound,
  output logic                     busy
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_count
`endif
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  winner;
  logic                grant_fire;
  pkt_t                pkt_sel;
  pkt_t                pkt_q;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  always_comb begin
    grant_fire = (state == ST_IDLE) && free_outbound && (|req) && !reset;
    gnt        = grant_fire ? winner : '0;
  end

  always_comb begin
    win_idx = '0;
    pkt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
        pkt_sel = pkt_in[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_fire) state_nxt = ST_B0;
      ST_B0:   state_nxt = ST_B1;
      ST_B1:   state_nxt = ST_B2;
      ST_B2:   state_nxt = ST_B3;
      ST_B3:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != ST_IDLE);
    put_outbound     = busy;
    payload_outbound = 8'h00;
    case (state)
      ST_B0:   payload_outbound = {pkt_q.src, pkt_q.dest};
      ST_B1:   payload_outbound = pkt_q.data[23:16];
      ST_B2:   payload_outbound = pkt_q.data[15:8];
      ST_B3:   payload_outbound = pkt_q.data[7:0];
      default: payload_outbound = 8'h00;
    endcase
  end

  // Packet and pointer only move on the grant edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_q  <= '0;
      rr_ptr <= '0;
    end else if (grant_fire) begin
      pkt_q <= pkt_sel;
      if (win_idx == PTR_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= win_idx + PTR_W'(1);
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (grant_count[i] != 16'hFFFF)) grant_count[i] <= grant_count[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Directed bench for router_out_arb with a packet-level reference model checked every cycle.
module tb_router_out_arb;
  import RouterPkg::*;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  pkt_t [N-1:0]  pkt_in;
  logic [N-1:0]  gnt;
  logic          free_outbound = 1'b0;
  logic          put_outbound;
  logic [7:0]    payload_outbound;
  logic          busy;
`ifdef ROUTER_ARB_STATS_EN
  logic [N-1:0][15:0] grant_count;
`endif

  router_out_arb #(.NUM_REQ(N), .PTR_W(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .pkt_in           (pkt_in),
    .gnt              (gnt),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .busy             (busy)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_count      (grant_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view (bytes left to send, pointer, counts).
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_w;
  logic [7:0]  m_bytes [4];
  logic [31:0] m_word;
  int          m_cnt [N];
  bit          chk_en = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    if (reset || m_phase != 0 || !free_outbound) return g;
    w = pick(req, m_ptr);
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      m_ptr   = 0;
      chk_en  = 1'b1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_phase == 0) begin
      m_w = free_outbound ? pick(req, m_ptr) : -1;
      if (m_w >= 0) begin
        m_word = pkt_in[m_w];
        for (int b = 0; b < 4; b++) m_bytes[b] = 8'(m_word >> (8 * (3 - b)));
        m_ptr   = (m_w + 1) % N;
        m_phase = 1;
        if (m_cnt[m_w] < 65535) m_cnt[m_w] = m_cnt[m_w] + 1;
      end
    end else begin
      m_phase = (m_phase == 4) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_gnt", 32'(gnt), 32'(exp_gnt()));
      check("model_put", 32'(put_outbound), 32'(m_phase != 0));
      check("model_busy", 32'(busy), 32'(m_phase != 0));
      check("model_payload", 32'(payload_outbound), (m_phase != 0) ? 32'(m_bytes[m_phase-1]) : 32'h0);
`ifdef ROUTER_ARB_STATS_EN
      for (int i = 0; i < N; i++) check("model_grant_count", 32'(grant_count[i]), 32'(m_cnt[i]));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] e;
    pkt_in = '0;
    repeat (3) step();
    @(negedge clock);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_put", 32'(put_outbound), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_payload", 32'(payload_outbound), 32'h0);

    // Single packet from port 0
    step();
    reset = 1'b0; free_outbound = 1'b1;
    pkt_in[0] = 32'h12345678; req = 4'b0001;
    @(negedge clock); check("single_gnt", 32'(gnt), 32'h1);
    step(); req = '0;
    @(negedge clock); check("single_b0", 32'(payload_outbound), 32'h12);
    step(); @(negedge clock); check("single_b1", 32'(payload_outbound), 32'h34);
    step(); @(negedge clock); check("single_b2", 32'(payload_outbound), 32'h56);
    step(); @(negedge clock); check("single_b3", 32'(payload_outbound), 32'h78);
    step(); @(negedge clock); check("single_idle_put", 32'(put_outbound), 32'h0);

    // Backpressure holds port 2 off until free_outbound rises
    step();
    free_outbound = 1'b0; req = 4'b0100; pkt_in[2] = 32'hA1B2C3D4;
    repeat (10) begin
      @(negedge clock);
      check("bp_gnt", 32'(gnt), 32'h0);
      check("bp_put", 32'(put_outbound), 32'h0);
      step();
    end
    free_outbound = 1'b1;
    @(negedge clock); check("bp_release_gnt", 32'(gnt), 32'h4);

    // Wrap from ptr 3 to port 0, then ptr 1 picks port 1
    step();
    req = 4'b0011; pkt_in[0] = 32'h0F1E2D3C; pkt_in[1] = 32'h4B5A6978;
    repeat (4) step();
    @(negedge clock); check("wrap_gnt", 32'(gnt), 32'h1);
    step();
    repeat (4) step();
    @(negedge clock); check("wrap_ptr_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;

    // Round robin with all ports requesting; free_outbound drops mid-packet
    reset = 1'b1;
    step();
    reset = 1'b0; req = 4'b1111;
    pkt_in[0] = 32'h01020304; pkt_in[1] = 32'h11223344;
    pkt_in[2] = 32'h55667788; pkt_in[3] = 32'h99AABBCC;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      @(negedge clock); check("rr_gnt", 32'(gnt), 32'(e));
      step(); free_outbound = 1'b0;
      step(); step(); step();
      free_outbound = 1'b1;
      step();
    end

    // Reset during B1 discards the packet; pointer returns to 0
    req = 4'b1000; pkt_in[3] = 32'hCAFEF00D;
    @(negedge clock); check("mid_gnt", 32'(gnt), 32'h8);
    step(); req = 4'b0110;
    step(); reset = 1'b1;
    @(negedge clock);
    check("mid_b1_payload", 32'(payload_outbound), 32'hFE);
    check("mid_b1_gnt", 32'(gnt), 32'h0);
    step(); reset = 1'b0;
    @(negedge clock);
    check("mid_after_put", 32'(put_outbound), 32'h0);
    check("mid_after_gnt", 32'(gnt), 32'h2);
    step(); req = '0;
    repeat (5) step();

    // Reset forces gnt low even with requests pending
    reset = 1'b1; req = 4'b1111; free_outbound = 1'b1;
    @(negedge clock); check("rst_forces_gnt0", 32'(gnt), 32'h0);
    step(); reset = 1'b0; req = '0;

`ifdef ROUTER_ARB_STATS_EN
    for (int k = 0; k < 3; k++) begin
      req = 4'b0010;
      @(negedge clock); check("stats_gnt_p1", 32'(gnt), 32'h2);
      step(); req = '0;
      repeat (4) step();
    end
    req = 4'b1000;
    @(negedge clock); check("stats_gnt_p3", 32'(gnt), 32'h8);
    step(); req = '0;
    repeat (4) step();
    @(negedge clock);
    check("stats_p0", 32'(grant_count[0]), 32'd0);
    check("stats_p1", 32'(grant_count[1]), 32'd3);
    check("stats_p2", 32'(grant_count[2]), 32'd0);
    check("stats_p3", 32'(grant_count[3]), 32'd1);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clock);
    check("stats_clr_p1", 32'(grant_count[1]), 32'd0);
    check("stats_clr_p3", 32'(grant_count[3]), 32'd0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
